// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ sweep sequencer.
// Holds the FSM state encoding, the default code width and the counter sizing helper.
package daq_pkg;

    localparam int DAQ_DATA_W  = 12;
    // One guard bit on code+step exposes overflow past the top code.
    localparam int SUM_GUARD_W = 1;

    typedef logic [2:0] daq_state_t;

    localparam daq_state_t ST_IDLE      = 3'd0;
    localparam daq_state_t ST_ISSUE     = 3'd1;
    localparam daq_state_t ST_WAIT_DONE = 3'd2;
    localparam daq_state_t ST_EMIT      = 3'd3;
    localparam daq_state_t ST_SETTLE    = 3'd4;
    localparam daq_state_t ST_FINISH    = 3'd5;

    function automatic int cnt_width(input int settle, input int timeout);
        int m;
        m = (settle > timeout) ? settle : timeout;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/daq_wdog_cnt.sv
// Loadable saturating down-counter shared by the settle delay and the done watchdog.
// Latency: load takes effect next cycle; zero is combinational from the count. No backpressure.
// Backpressure: none; en simply stalls the count.
module daq_wdog_cnt #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/daq_sweep_sequencer.sv
// Steps a DAQ core through a DAC code sweep and streams (dac, adc) pairs; optional DAQ_SWEEP_MINMAX_EN adds min/max tracking.
// Latency: daq_start one cycle after cfg_start; a result appears the cycle after daq_done.
// Backpressure: res_valid holds all result fields until res_ready; the sweep stalls meanwhile.
module daq_sweep_sequencer
    import daq_pkg::*;
#(
    parameter int DATA_W         = DAQ_DATA_W,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [DATA_W-1:0] cfg_start_code,
    input  logic [DATA_W-1:0] cfg_stop_code,
    input  logic [DATA_W-1:0] cfg_step,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              daq_start,
    output logic [DATA_W-1:0] daq_din,
    input  logic [DATA_W-1:0] daq_dout,
    input  logic              daq_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_dac_code,
    output logic [DATA_W-1:0] res_adc_code,
    output logic              res_last
`ifdef DAQ_SWEEP_MINMAX_EN
    ,
    output logic [DATA_W-1:0] min_code,
    output logic [DATA_W-1:0] max_code,
    output logic              minmax_valid
`endif
);

    localparam int SUM_W = DATA_W + SUM_GUARD_W;
    localparam int CNT_W = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    // Watchdog hits zero in the last WAIT_DONE cycle, so expiry lands TIMEOUT_CYCLES after daq_start.
    localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    daq_state_t        state;
    daq_state_t        state_nxt;
    logic [DATA_W-1:0] code;
    logic [DATA_W-1:0] stop_code;
    logic [DATA_W-1:0] step;
    logic              abort_pend;
    logic [SUM_W-1:0]  sum;
    logic              last_point;
    logic              capture;
    logic              expire;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;

    daq_wdog_cnt #(.CNT_W(CNT_W)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    assign sum        = SUM_W'(code) + SUM_W'(step);
    assign last_point = (step == '0) || (sum > SUM_W'(stop_code)) || sum[DATA_W]
                        || abort_pend || cfg_abort;
    assign capture    = (state == ST_WAIT_DONE) && daq_done;
    assign expire     = (state == ST_WAIT_DONE) && !daq_done && cnt_zero;

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = TO_LOAD;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_DONE;
                cnt_load  = 1'b1;
            end
            ST_WAIT_DONE: begin
                cnt_en = 1'b1;
                if (daq_done)      state_nxt = ST_EMIT;
                else if (cnt_zero) state_nxt = ST_FINISH;
            end
            ST_EMIT: begin
                if (res_ready) begin
                    if (res_last) begin
                        state_nxt = ST_FINISH;
                    end else if (SETTLE_CYCLES == 0) begin
                        state_nxt = abort_pend ? ST_FINISH : ST_ISSUE;
                    end else begin
                        state_nxt    = ST_SETTLE;
                        cnt_load     = 1'b1;
                        cnt_load_val = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                cnt_en = 1'b1;
                if (abort_pend)    state_nxt = ST_FINISH;
                else if (cnt_zero) state_nxt = ST_ISSUE;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            code         <= '0;
            stop_code    <= '0;
            step         <= '0;
            abort_pend   <= 1'b0;
            res_adc_code <= '0;
            res_last     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && cfg_start) begin
                code        <= cfg_start_code;
                stop_code   <= cfg_stop_code;
                step        <= cfg_step;
                timeout_err <= 1'b0;
            end
            if (capture) begin
                res_adc_code <= daq_dout;
                res_last     <= last_point;
            end
            if (expire) timeout_err <= 1'b1;
            if ((state == ST_EMIT) && res_ready && !res_last) code <= sum[DATA_W-1:0];
            if (state == ST_IDLE)  abort_pend <= 1'b0;
            else if (cfg_abort)    abort_pend <= 1'b1;
        end
    end

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FINISH);
    assign daq_start    = (state == ST_ISSUE);
    assign daq_din      = code;
    assign res_valid    = (state == ST_EMIT);
    assign res_dac_code = code;

`ifdef DAQ_SWEEP_MINMAX_EN
    logic first_cap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_code     <= '0;
            max_code     <= '0;
            minmax_valid <= 1'b0;
            first_cap    <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cfg_start) begin
                minmax_valid <= 1'b0;
                first_cap    <= 1'b1;
            end
            if (capture) begin
                if (first_cap || (daq_dout < min_code)) min_code <= daq_dout;
                if (first_cap || (daq_dout > max_code)) max_code <= daq_dout;
                first_cap <= 1'b0;
            end
            if (state == ST_FINISH) minmax_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_daq_sweep_sequencer.sv
// Randomised self-checking bench: a DAQ core model answers each daq_start, and a scoreboard
// compares every result against point lists computed directly from the sweep rules.
module tb_daq_sweep_sequencer;

    localparam int DATA_W  = 12;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 4096;
    localparam int MAXC    = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_start, cfg_abort;
    logic [DATA_W-1:0] cfg_start_code, cfg_stop_code, cfg_step;
    logic              busy, done, timeout_err, daq_start;
    logic [DATA_W-1:0] daq_din, daq_dout;
    logic              daq_done;
    logic              res_valid, res_ready, res_last;
    logic [DATA_W-1:0] res_dac_code, res_adc_code;
`ifdef DAQ_SWEEP_MINMAX_EN
    logic [DATA_W-1:0] min_code, max_code;
    logic              minmax_valid;
`endif

    daq_sweep_sequencer #(
        .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_start_code(cfg_start_code), .cfg_stop_code(cfg_stop_code), .cfg_step(cfg_step),
        .busy(busy), .done(done), .timeout_err(timeout_err), .daq_start(daq_start),
        .daq_din(daq_din), .daq_dout(daq_dout), .daq_done(daq_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_dac_code(res_dac_code),
        .res_adc_code(res_adc_code), .res_last(res_last)
`ifdef DAQ_SWEEP_MINMAX_EN
        , .min_code(min_code), .max_code(max_code), .minmax_valid(minmax_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard and model state
    int exp_dac_q[$];
    int exp_last_q[$];
    int adc_q[$];
    bit never_done  = 1'b0;
    int ready_mode  = 0;
    int bp_cnt      = 0;
    int stall_cnt   = 0;
    int n_starts    = 0;
    int n_done      = 0;
    int n_hs        = 0;
    int hs_base     = 0;
    bit gap_pending = 1'b0;
    int hs_cyc      = 0;
    int last_start_cyc = 0;
    int to_rise_cyc    = 0;
    int exp_min, exp_max;
    bit mm_first;

    // DAQ core model: answers each daq_start after a random 2..30 cycle latency.
    initial begin
        daq_done = 1'b0;
        daq_dout = '0;
        forever begin
            @(negedge clk);
            if (daq_start && !reset && !never_done) begin
                int lat, v, din_seen;
                din_seen = int'(daq_din);
                lat = $urandom_range(2, 30);
                v   = $urandom_range(0, MAXC);
                repeat (lat) @(posedge clk);
                #1;
                daq_done = 1'b1;
                daq_dout = DATA_W'(v);
                adc_q.push_back(v);
                if (mm_first || v < exp_min) exp_min = v;
                if (mm_first || v > exp_max) exp_max = v;
                mm_first = 1'b0;
                @(negedge clk);
                if (busy) check_val("daq_din_stable", daq_din, din_seen);
                @(posedge clk);
                #1 daq_done = 1'b0;
            end
        end
    end

    // Downstream ready generator
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (res_valid && (n_hs - hs_base == 1) && bp_cnt < 50) begin
                        res_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: counts events, checks hold-under-stall, settle gap and each accepted result.
    initial begin
        bit pv, pr, pl, pto;
        int pd, pa;
        pv = 0; pr = 0; pl = 0; pto = 0; pd = 0; pa = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0;
                pto = 0;
            end else begin
                if (daq_start) begin
                    n_starts++;
                    last_start_cyc = cyc;
                    if (gap_pending) begin
                        check_val("settle_gap", cyc - hs_cyc, SETTLE + 1);
                        gap_pending = 1'b0;
                    end
                end
                if (done) n_done++;
                if (timeout_err && !pto) to_rise_cyc = cyc;
                pto = timeout_err;
                if (pv && !pr) begin
                    check_val("hold_valid", res_valid, 1);
                    check_val("hold_dac", res_dac_code, pd);
                    check_val("hold_adc", res_adc_code, pa);
                    check_val("hold_last", res_last, pl);
                end
                if (res_valid && !res_ready) stall_cnt++;
                if (res_valid && res_ready) begin
                    if (exp_dac_q.size() == 0 || adc_q.size() == 0) begin
                        check_val("unexpected_result", 1, 0);
                    end else begin
                        check_val("res_dac", res_dac_code, exp_dac_q.pop_front());
                        check_val("res_adc", res_adc_code, adc_q.pop_front());
                        check_val("res_last", res_last, exp_last_q.pop_front());
                    end
                    n_hs++;
                    if (!res_last) begin
                        gap_pending = 1'b1;
                        hs_cyc = cyc;
                    end
                end
                pv = res_valid; pr = res_ready; pl = res_last;
                pd = int'(res_dac_code); pa = int'(res_adc_code);
            end
        end
    end

    task automatic run_sweep(input int s, input int stp, input int sp, input int abort_at,
                             input bit to_mode, input int rmode);
        int c, npts, starts0, done0, guard;
        bit fin, aborted;
        exp_dac_q.delete();
        exp_last_q.delete();
        adc_q.delete();
        c = s; npts = 0; fin = 0;
        while (!to_mode && !fin) begin
            npts++;
            exp_dac_q.push_back(c);
            if (stp == 0 || c + stp > sp || c + stp > MAXC || (abort_at > 0 && npts == abort_at)) begin
                exp_last_q.push_back(1);
                fin = 1;
            end else begin
                exp_last_q.push_back(0);
                c += stp;
            end
        end
        never_done = to_mode; ready_mode = rmode; bp_cnt = 0; stall_cnt = 0;
        hs_base = n_hs; gap_pending = 0; mm_first = 1;
        starts0 = n_starts; done0 = n_done;
        @(posedge clk);
        #1;
        cfg_start_code = DATA_W'(s); cfg_stop_code = DATA_W'(sp); cfg_step = DATA_W'(stp);
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        @(negedge clk);
        check_val("busy_after_start", busy, 1);
        check_val("daq_start_latency", daq_start, 1);
        check_val("timeout_err_cleared", timeout_err, 0);
        guard = 0; aborted = 0;
        while (n_done == done0 && guard < 20000) begin
            @(negedge clk);
            guard++;
            cfg_abort = 1'b0;
            if (abort_at > 0 && !aborted && (n_starts - starts0) >= abort_at && !daq_start) begin
                cfg_abort = 1'b1;
                aborted = 1;
            end
        end
        cfg_abort = 1'b0;
        check_val("sweep_done_seen", (n_done != done0), 1);
        repeat (5) @(negedge clk);
        check_val("done_pulses", n_done - done0, 1);
        check_val("idle_after_sweep", busy, 0);
        check_val("daq_starts", n_starts - starts0, to_mode ? 1 : npts);
        check_val("results_missing", exp_dac_q.size(), 0);
        check_val("timeout_err", timeout_err, to_mode);
        if (to_mode) check_val("timeout_latency", to_rise_cyc - last_start_cyc, TIMEOUT);
        if (rmode == 2 && npts >= 2) check_val("stall_cycles", stall_cnt, 50);
`ifdef DAQ_SWEEP_MINMAX_EN
        check_val("minmax_valid", minmax_valid, 1);
        if (!to_mode) begin
            check_val("min_code", min_code, exp_min);
            check_val("max_code", max_code, exp_max);
        end
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int s, stp, sp, d0;
        reset = 1'b1; cfg_start = 0; cfg_abort = 0;
        cfg_start_code = '0; cfg_stop_code = '0; cfg_step = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_daq_start", daq_start, 0);
        check_val("rst_daq_din", daq_din, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_last", res_last, 0);
        check_val("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        run_sweep(100, 10, 130, 0, 0, 0);     // four points, last at 130
        run_sweep(4090, 8, 4095, 0, 0, 0);    // overflow and beyond-stop
        run_sweep(500, 0, 900, 0, 0, 1);      // zero step
        run_sweep(200, 5, 100, 0, 0, 0);      // start above stop
        run_sweep(100, 10, 130, 0, 0, 2);     // 50-cycle stall on point two
        run_sweep(100, 10, 200, 2, 0, 1);     // abort during point two
        run_sweep(300, 10, 400, 0, 1, 0);     // watchdog expiry
        run_sweep(0, 1, 3, 0, 0, 1);          // recovery clears timeout_err

        // Reset in the middle of a sweep: back to idle, no done pulse.
        ready_mode = 3; never_done = 0;
        @(posedge clk);
        #1;
        cfg_start_code = 12'd50; cfg_stop_code = 12'd90; cfg_step = 12'd10; cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        repeat (6) @(posedge clk);
        d0 = n_done;
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_res_valid", res_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (60) @(negedge clk);
        check_val("midrst_no_done", n_done - d0, 0);
        check_val("midrst_idle", busy, 0);

        for (int i = 0; i < 10; i++) begin
            s   = $urandom_range(0, MAXC);
            stp = $urandom_range(1, 60);
            sp  = s + $urandom_range(0, stp * 5);
            if (sp > MAXC) sp = MAXC;
            run_sweep(s, stp, sp, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
